// File: rtl/sign_run_counter.sv
// Measures runs of consecutive sign-high cycles and hands runs of at least
// RUN_MIN cycles to a one-deep valid/ready output slot, counting loaded events.
module sign_run_counter #(
  parameter int RUN_MIN = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sign,
  input  logic             clr,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_len,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             ovf
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  localparam logic [7:0] RunMinL = 8'(RUN_MIN);

  state_e             state_q, state_d;
  logic [7:0]         run_len_q, run_len_d;
  logic               evt_valid_q, evt_valid_d;
  logic [7:0]         evt_len_q, evt_len_d;
  logic [CNT_W-1:0]   evt_cnt_q, evt_cnt_d;
  logic               ovf_q, ovf_d;
  logic               qual;
  logic               slot_free;

  // A run ends on the first low sample; its length is the pre-edge count.
  assign qual      = (state_q == RUN) && !sign && (run_len_q >= RunMinL);
  assign slot_free = !evt_valid_q || evt_ready;

  always_comb begin
    state_d     = state_q;
    run_len_d   = run_len_q;
    evt_valid_d = evt_valid_q;
    evt_len_d   = evt_len_q;
    evt_cnt_d   = evt_cnt_q;
    ovf_d       = ovf_q;

    case (state_q)
      IDLE: begin
        if (sign) begin
          state_d   = RUN;
          run_len_d = 8'd1;
        end else begin
          run_len_d = 8'd0;
        end
      end
      RUN: begin
        if (sign) begin
          if (run_len_q != 8'hFF) run_len_d = run_len_q + 8'd1;
        end else begin
          state_d   = IDLE;
          run_len_d = 8'd0;
        end
      end
      default: begin
        state_d   = IDLE;
        run_len_d = 8'd0;
      end
    endcase

    // A transfer on the same edge frees the slot for the new record.
    if (qual && slot_free) begin
      evt_valid_d = 1'b1;
      evt_len_d   = run_len_q;
      evt_cnt_d   = evt_cnt_q + 1'b1;
    end else if (qual) begin
      ovf_d = 1'b1;
    end else if (evt_valid_q && evt_ready) begin
      evt_valid_d = 1'b0;
    end

    if (clr) begin
      state_d     = IDLE;
      run_len_d   = 8'd0;
      evt_valid_d = 1'b0;
      evt_len_d   = 8'd0;
      evt_cnt_d   = '0;
      ovf_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      run_len_q   <= 8'd0;
      evt_valid_q <= 1'b0;
      evt_len_q   <= 8'd0;
      evt_cnt_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_len_q   <= run_len_d;
      evt_valid_q <= evt_valid_d;
      evt_len_q   <= evt_len_d;
      evt_cnt_q   <= evt_cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_len   = evt_len_q;
  assign evt_cnt   = evt_cnt_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_sign_run_counter.sv
// Directed bench for sign_run_counter: default instance plus a CNT_W=4
// instance sharing the same stimulus for the counter-wrap case.
module tb_sign_run_counter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sign, clr, evt_ready;
  logic        evt_valid, ovf;
  logic [7:0]  evt_len;
  logic [15:0] evt_cnt;
  logic        s_valid, s_ovf;
  logic [7:0]  s_len;
  logic [3:0]  s_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sign_run_counter #(.RUN_MIN(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .sign(sign), .clr(clr),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_len(evt_len), .evt_cnt(evt_cnt), .ovf(ovf)
  );

  sign_run_counter #(.RUN_MIN(4), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .sign(sign), .clr(clr),
    .evt_valid(s_valid), .evt_ready(evt_ready),
    .evt_len(s_len), .evt_cnt(s_cnt), .ovf(s_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Outputs are sampled 1 time unit after the edge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n high cycles, then one low sample that ends the run.
  task automatic run(input int n);
    sign = 1'b1;
    repeat (n) tick();
    sign = 1'b0;
    tick();
  endtask

  task automatic chk_all0(input string tag);
    chk({tag, "_valid"}, {31'd0, evt_valid}, 0);
    chk({tag, "_len"},   {24'd0, evt_len},   0);
    chk({tag, "_cnt"},   {16'd0, evt_cnt},   0);
    chk({tag, "_ovf"},   {31'd0, ovf},       0);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; sign = 1'b0; clr = 1'b0; evt_ready = 1'b1;
    #2;
    chk_all0("reset");
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk_all0("post_reset");

    // Basic event, latency 1, transfer next cycle.
    run(6);
    chk("r6_valid", {31'd0, evt_valid}, 1);
    chk("r6_len",   {24'd0, evt_len},   6);
    chk("r6_cnt",   {16'd0, evt_cnt},   1);
    tick();
    chk("r6_drain", {31'd0, evt_valid}, 0);

    // Short runs are discarded.
    do_clr();
    for (int r = 0; r < 2; r++) begin
      sign = 1'b1;
      for (int c = 0; c < 4; c++) begin
        if (c == 3) sign = 1'b0;
        tick();
        chk("short_valid", {31'd0, evt_valid}, 0);
      end
      tick();
    end
    chk("short_cnt", {16'd0, evt_cnt}, 0);

    // Full slot drops second run and sets sticky ovf.
    evt_ready = 1'b0;
    run(5);
    chk("f5_len", {24'd0, evt_len}, 5);
    chk("f5_ovf", {31'd0, ovf},     0);
    run(7);
    chk("f7_valid", {31'd0, evt_valid}, 1);
    chk("f7_len",   {24'd0, evt_len},   5);
    chk("f7_cnt",   {16'd0, evt_cnt},   1);
    chk("f7_ovf",   {31'd0, ovf},       1);
    evt_ready = 1'b1;
    tick();
    chk("f_xfer_valid", {31'd0, evt_valid}, 0);
    chk("f_xfer_ovf",   {31'd0, ovf},       1);
    tick();
    chk("f_hold_cnt", {16'd0, evt_cnt}, 1);

    // Transfer coincides with a qualifying run end.
    do_clr();
    chk("clr_ovf", {31'd0, ovf}, 0);
    evt_ready = 1'b0;
    run(4);
    chk("c4_len", {24'd0, evt_len}, 4);
    sign = 1'b1;
    repeat (9) tick();
    sign = 1'b0;
    evt_ready = 1'b1;
    tick();
    chk("c9_valid", {31'd0, evt_valid}, 1);
    chk("c9_len",   {24'd0, evt_len},   9);
    chk("c9_cnt",   {16'd0, evt_cnt},   2);
    chk("c9_ovf",   {31'd0, ovf},       0);
    tick();
    chk("c9_drain", {31'd0, evt_valid}, 0);

    // Length saturation.
    run(300);
    chk("sat_valid", {31'd0, evt_valid}, 1);
    chk("sat_len",   {24'd0, evt_len},   255);
    chk("sat_cnt",   {16'd0, evt_cnt},   3);
    tick();

    // Counter wrap on the narrow instance.
    do_clr();
    for (int r = 0; r < 17; r++) run(4);
    chk("wrap_cnt4",  {28'd0, s_cnt},   1);
    chk("wrap_cnt16", {16'd0, evt_cnt}, 17);
    chk("wrap_len4",  {24'd0, s_len},   4);
    tick();

    // Asynchronous reset mid-run.
    sign = 1'b1;
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    chk_all0("arst");
    sign = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk_all0("arst_rel");
    run(4);
    chk("arst_len", {24'd0, evt_len}, 4);
    chk("arst_cnt", {16'd0, evt_cnt}, 1);
    tick();

    // Synchronous clear with slot full and ovf set.
    evt_ready = 1'b0;
    run(4);
    run(4);
    chk("pre_clr_valid", {31'd0, evt_valid}, 1);
    chk("pre_clr_ovf",   {31'd0, ovf},       1);
    clr = 1'b1;
    #1;
    chk("clr_sync_valid", {31'd0, evt_valid}, 1);
    tick();
    clr = 1'b0;
    chk_all0("clr");
    evt_ready = 1'b1;
    run(4);
    chk("clr_len", {24'd0, evt_len}, 4);
    chk("clr_cnt", {16'd0, evt_cnt}, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
